// File: rtl/sme_alu_issue.sv
// SME ALU issue stage: gathers rs1/rs2 shares from the share bank, hands them to
// the ALU over valid/ready, then writes the result shares back to rd.

module sme_alu_share #(
    parameter int XLEN = 32
) (
    input  logic            g_clk,
    input  logic            g_reset,
    input  logic            clr,
    input  logic            cap_en,
    input  logic            cap_sel,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] rs1,
    output logic [XLEN-1:0] rs2
);
    logic [XLEN-1:0] rs1_q, rs2_q;

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            rs1_q <= '0;
            rs2_q <= '0;
        end else if (clr) begin
            rs1_q <= '0;
            rs2_q <= '0;
        end else if (cap_en) begin
            if (cap_sel) rs2_q <= rdata;
            else         rs1_q <= rdata;
        end
    end

    // Bypass the share being captured so the ALU sees a complete operand in the
    // first ISSUE cycle; the registered copy holds the same value afterwards.
    assign rs1 = (cap_en && !cap_sel) ? rdata : rs1_q;
    assign rs2 = (cap_en &&  cap_sel) ? rdata : rs2_q;
endmodule

module sme_alu_issue #(
    parameter int XLEN = 32,
    parameter int SMAX = 4
) (
    input  logic                 g_clk,
    input  logic                 g_reset,
    input  logic [3:0]           smectl_d,
    input  logic                 flush,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [3:0]           cmd_op,
    input  logic [4:0]           cmd_rs1,
    input  logic [4:0]           cmd_rs2,
    input  logic [4:0]           cmd_rd,
    input  logic [4:0]           cmd_shamt,
    output logic                 bank_ren,
    output logic [4:0]           bank_raddr,
    output logic [3:0]           bank_rshare,
    input  logic [XLEN-1:0]      bank_rdata,
    output logic                 bank_wen,
    output logic [4:0]           bank_waddr,
    output logic [3:0]           bank_wshare,
    output logic [XLEN-1:0]      bank_wdata,
    output logic                 alu_valid,
    input  logic                 alu_ready,
    output logic [11:0]          alu_op,
    output logic [4:0]           alu_shamt,
    output logic [SMAX*XLEN-1:0] alu_rs1,
    output logic [SMAX*XLEN-1:0] alu_rs2,
    input  logic [SMAX*XLEN-1:0] alu_rd,
    output logic                 done,
    output logic                 err
);
    localparam int SIW = (SMAX > 1) ? $clog2(SMAX) : 1;

    typedef enum logic [2:0] {IDLE, RD1, RD2, ISSUE, WR} state_t;
    state_t state, state_nx;

    logic [3:0]  cnt, d_eff, d_in;
    logic [4:0]  rs1_q, rs2_q, rd_q;
    logic        cap_vld, cap_sel, err_q, legal, accept, last, unary;
    logic [3:0]  cap_idx;
    logic [SMAX-1:0][XLEN-1:0] rs1_sh, rs2_sh, rd_sh;

    assign legal  = cmd_op < 4'd12;
    assign accept = (state == IDLE) && cmd_valid && !flush && legal;
    assign last   = cnt == d_eff - 4'd1;
    assign unary  = |alu_op[11:8];

    always_comb begin
        d_in = smectl_d;
        if (smectl_d < 4'd2)          d_in = 4'd2;
        else if (smectl_d > 4'(SMAX)) d_in = 4'(SMAX);
    end

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        cmd_ready   = state == IDLE;
        bank_ren    = 1'b0;
        bank_raddr  = '0;
        bank_rshare = '0;
        bank_wen    = 1'b0;
        bank_waddr  = '0;
        bank_wshare = '0;
        bank_wdata  = '0;
        alu_valid   = 1'b0;
        done        = 1'b0;
        case (state)
            IDLE:  if (accept) state_nx = RD1;
            RD1: begin
                bank_ren    = 1'b1;
                bank_raddr  = rs1_q;
                bank_rshare = cnt;
                if (last) state_nx = unary ? ISSUE : RD2;
            end
            RD2: begin
                bank_ren    = 1'b1;
                bank_raddr  = rs2_q;
                bank_rshare = cnt;
                if (last) state_nx = ISSUE;
            end
            ISSUE: begin
                alu_valid = 1'b1;
                if (alu_ready) state_nx = WR;
            end
            WR: begin
                // rd==0 still walks the WR cycles so done keeps its fixed latency
                bank_wen    = rd_q != 5'd0;
                bank_waddr  = rd_q;
                bank_wshare = cnt;
                bank_wdata  = rd_sh[cnt[SIW-1:0]];
                done        = last;
                if (last) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (flush) begin
            state_nx  = IDLE;
            bank_ren  = 1'b0;
            bank_wen  = 1'b0;
            alu_valid = 1'b0;
            done      = 1'b0;
        end
    end

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            cnt       <= '0;
            d_eff     <= 4'd2;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            alu_op    <= '0;
            alu_shamt <= '0;
            cap_vld   <= 1'b0;
            cap_sel   <= 1'b0;
            cap_idx   <= '0;
            rd_sh     <= '0;
            err_q     <= 1'b0;
        end else begin
            if (state_nx != state)                      cnt <= '0;
            else if (state != IDLE && state != ISSUE)   cnt <= cnt + 4'd1;
            if (accept) begin
                d_eff     <= d_in;
                rs1_q     <= cmd_rs1;
                rs2_q     <= cmd_rs2;
                rd_q      <= cmd_rd;
                alu_op    <= 12'd1 << cmd_op;
                alu_shamt <= cmd_shamt;
            end
            cap_vld <= bank_ren;
            cap_sel <= state == RD2;
            cap_idx <= cnt;
            if (alu_valid && alu_ready) rd_sh <= alu_rd;
            err_q <= (state == IDLE) && cmd_valid && !flush && !legal;
        end
    end

    assign err = err_q;

    for (genvar i = 0; i < SMAX; i++) begin : g_share
        sme_alu_share #(.XLEN(XLEN)) u_share (
            .g_clk   (g_clk),
            .g_reset (g_reset),
            .clr     (accept),
            .cap_en  (cap_vld && cap_idx == 4'(i)),
            .cap_sel (cap_sel),
            .rdata   (bank_rdata),
            .rs1     (rs1_sh[i]),
            .rs2     (rs2_sh[i])
        );
    end

    assign alu_rs1 = rs1_sh;
    assign alu_rs2 = rs2_sh;
endmodule

// File: tb/tb_sme_alu_issue.sv
// Directed bench for sme_alu_issue: share bank model, stub ALU with a
// programmable ready delay, and a negedge monitor counting bank/ALU activity.

module tb_sme_alu_issue;
    localparam int XLEN = 32;
    localparam int SMAX = 4;

    logic g_clk = 1'b0, g_reset = 1'b1;
    logic [3:0] smectl_d = '0, cmd_op = '0;
    logic flush = 1'b0, cmd_valid = 1'b0, cmd_ready;
    logic [4:0] cmd_rs1 = '0, cmd_rs2 = '0, cmd_rd = '0, cmd_shamt = '0;
    logic bank_ren, bank_wen, alu_valid, alu_ready, done, err;
    logic [4:0] bank_raddr, bank_waddr, alu_shamt;
    logic [3:0] bank_rshare, bank_wshare;
    logic [XLEN-1:0] bank_rdata = '0, bank_wdata;
    logic [11:0] alu_op;
    logic [SMAX*XLEN-1:0] alu_rs1, alu_rs2, alu_rd;

    sme_alu_issue #(.XLEN(XLEN), .SMAX(SMAX)) dut (
        .g_clk(g_clk), .g_reset(g_reset), .smectl_d(smectl_d), .flush(flush),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_rd(cmd_rd), .cmd_shamt(cmd_shamt),
        .bank_ren(bank_ren), .bank_raddr(bank_raddr), .bank_rshare(bank_rshare),
        .bank_rdata(bank_rdata), .bank_wen(bank_wen), .bank_waddr(bank_waddr),
        .bank_wshare(bank_wshare), .bank_wdata(bank_wdata), .alu_valid(alu_valid),
        .alu_ready(alu_ready), .alu_op(alu_op), .alu_shamt(alu_shamt),
        .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_rd(alu_rd), .done(done), .err(err)
    );

    always #5 g_clk = ~g_clk;

    logic [XLEN-1:0] bank [32][4];
    int cyc = 0, vcnt = 0, ready_lat = 0;
    int npass = 0, ntot = 0;

    always @(posedge g_clk) cyc <= cyc + 1;
    always @(posedge g_clk) if (bank_ren) bank_rdata <= bank[bank_raddr][bank_rshare[1:0]];
    always @(posedge g_clk) vcnt <= alu_valid ? vcnt + 1 : 0;
    assign alu_ready = alu_valid && (vcnt >= ready_lat);

    // Stub ALU: share-wise xor / and / add, mask xors a fixed pattern.
    always_comb begin
        alu_rd = '0;
        for (int s = 0; s < SMAX; s++) begin
            if (alu_op[0])       alu_rd[s*XLEN +: XLEN] = alu_rs1[s*XLEN +: XLEN] ^ alu_rs2[s*XLEN +: XLEN];
            else if (alu_op[2])  alu_rd[s*XLEN +: XLEN] = alu_rs1[s*XLEN +: XLEN] & alu_rs2[s*XLEN +: XLEN];
            else if (alu_op[6])  alu_rd[s*XLEN +: XLEN] = alu_rs1[s*XLEN +: XLEN] + alu_rs2[s*XLEN +: XLEN];
            else if (alu_op[10]) alu_rd[s*XLEN +: XLEN] = alu_rs1[s*XLEN +: XLEN] ^ 32'hA5A5_0000;
        end
    end

    int nrd = 0, nwr = 0, nvalid = 0, nunst = 0, ndone = 0, nerr = 0, nbusy = 0, done_cyc = 0;
    logic prev_v = 1'b0;
    logic [2*SMAX*XLEN+16:0] snap = '0;
    logic [SMAX*XLEN-1:0] rs1_seen = '0, rs2_seen = '0;
    logic [4:0] wlog_a [64];
    logic [3:0] wlog_s [64];
    logic [XLEN-1:0] wlog_d [64];

    always @(negedge g_clk) begin
        if (!g_reset) begin
            if (bank_ren) nrd <= nrd + 1;
            if (bank_wen && nwr < 64) begin
                wlog_a[nwr] <= bank_waddr;
                wlog_s[nwr] <= bank_wshare;
                wlog_d[nwr] <= bank_wdata;
                nwr <= nwr + 1;
            end
            if (alu_valid) begin
                nvalid <= nvalid + 1;
                if (prev_v && {alu_op, alu_shamt, alu_rs1, alu_rs2} != snap) nunst <= nunst + 1;
                snap     <= {alu_op, alu_shamt, alu_rs1, alu_rs2};
                rs1_seen <= alu_rs1;
                rs2_seen <= alu_rs2;
            end
            prev_v <= alu_valid;
            if (done) begin ndone <= ndone + 1; done_cyc <= cyc; end
            if (err) nerr <= nerr + 1;
            if (!cmd_ready) nbusy <= nbusy + 1;
        end
    end

    int b_rd, b_wr, b_v, b_unst, b_done, b_err, b_busy, acc_cyc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        ntot++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic send(input logic [3:0] op, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] rd, input logic [3:0] d, input int lat);
        @(posedge g_clk); #1;
        b_rd = nrd; b_wr = nwr; b_v = nvalid; b_unst = nunst;
        b_done = ndone; b_err = nerr; b_busy = nbusy; acc_cyc = cyc;
        ready_lat = lat;
        cmd_op = op; cmd_rs1 = r1; cmd_rs2 = r2; cmd_rd = rd; cmd_shamt = 5'd7;
        smectl_d = d; cmd_valid = 1'b1;
        @(posedge g_clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int lat);
        for (int i = 0; i < 200 && ndone == b_done; i++) @(posedge g_clk);
        repeat (3) @(posedge g_clk);
        #1;
        chk({tag, "_done_cnt"}, 64'(ndone - b_done), 64'd1);
        chk({tag, "_done_lat"}, 64'(done_cyc - acc_cyc), 64'(lat));
    endtask

    initial begin
        for (int r = 0; r < 32; r++)
            for (int s = 0; s < 4; s++) bank[r][s] = 32'hDEAD_0000 + 32'(r * 4 + s);
        bank[1][0] = 5;  bank[1][1] = 3;
        bank[2][0] = 6;  bank[2][1] = 1;
        bank[4][0] = 10; bank[4][1] = 20; bank[4][2] = 30; bank[4][3] = 40;
        bank[5][0] = 1;  bank[5][1] = 2;  bank[5][2] = 3;  bank[5][3] = 4;
        bank[7][0] = 100; bank[7][1] = 200; bank[7][2] = 300; bank[7][3] = 999;

        repeat (3) @(posedge g_clk);
        #1;
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_quiet", 64'({bank_ren, bank_wen, alu_valid, done, err}), 64'd0);
        chk("rst_alu_op", 64'(alu_op), 64'd0);
        chk("rst_operands", 64'(alu_rs1[63:0] | alu_rs2[63:0]), 64'd0);
        g_reset = 1'b0;

        // d=2 xor r1^r2 -> r3
        send(4'd0, 5'd1, 5'd2, 5'd3, 4'd2, 0);
        wait_done("xor", 7);
        chk("xor_reads", 64'(nrd - b_rd), 64'd4);
        chk("xor_valid_cycles", 64'(nvalid - b_v), 64'd1);
        chk("xor_writes", 64'(nwr - b_wr), 64'd2);
        chk("xor_w0", {27'd0, wlog_a[b_wr], wlog_s[b_wr], wlog_d[b_wr]}, {27'd0, 5'd3, 4'd0, 32'd3});
        chk("xor_w1", {27'd0, wlog_a[b_wr+1], wlog_s[b_wr+1], wlog_d[b_wr+1]}, {27'd0, 5'd3, 4'd1, 32'd2});
        chk("xor_shamt", 64'(alu_shamt), 64'd7);

        // d=4 add r4+r5 -> r6, ALU answers after 5 waiting cycles
        send(4'd6, 5'd4, 5'd5, 5'd6, 4'd4, 5);
        wait_done("add", 18);
        chk("add_valid_cycles", 64'(nvalid - b_v), 64'd6);
        chk("add_stable", 64'(nunst - b_unst), 64'd0);
        chk("add_writes", 64'(nwr - b_wr), 64'd4);
        chk("add_w0", 64'(wlog_d[b_wr]), 64'd11);
        chk("add_w3", {27'd0, wlog_a[b_wr+3], wlog_s[b_wr+3], wlog_d[b_wr+3]}, {27'd0, 5'd6, 4'd3, 32'd44});

        // d=3 mask (unary) r7 -> r8
        send(4'd10, 5'd7, 5'd9, 5'd8, 4'd3, 0);
        wait_done("mask", 7);
        chk("mask_reads", 64'(nrd - b_rd), 64'd3);
        chk("mask_rs2_zero", 64'(rs2_seen != '0), 64'd0);
        chk("mask_rs1_s2", 64'(rs1_seen[2*XLEN +: XLEN]), 64'd300);
        chk("mask_rs1_s3", 64'(rs1_seen[3*XLEN +: XLEN]), 64'd0);
        chk("mask_writes", 64'(nwr - b_wr), 64'd3);
        chk("mask_w2", 64'(wlog_d[b_wr+2]), 64'hA5A5_012C);

        // illegal op
        send(4'd13, 5'd1, 5'd2, 5'd3, 4'd2, 0);
        repeat (4) @(posedge g_clk);
        #1;
        chk("ill_err", 64'(nerr - b_err), 64'd1);
        chk("ill_activity", 64'((nrd - b_rd) + (nwr - b_wr) + (nvalid - b_v)), 64'd0);
        chk("ill_busy", 64'(nbusy - b_busy), 64'd0);

        // flush while ISSUE of and waits on the ALU
        send(4'd2, 5'd1, 5'd2, 5'd3, 4'd2, 1000);
        for (int i = 0; i < 50 && !alu_valid; i++) begin @(posedge g_clk); #1; end
        chk("flush_reach_issue", 64'(alu_valid), 64'd1);
        flush = 1'b1;
        #1;
        chk("flush_valid_drop", 64'(alu_valid), 64'd0);
        @(posedge g_clk); #1;
        flush = 1'b0;
        chk("flush_idle", 64'(cmd_ready), 64'd1);
        repeat (5) @(posedge g_clk);
        #1;
        chk("flush_no_wr_done", 64'((nwr - b_wr) + (ndone - b_done)), 64'd0);

        send(4'd0, 5'd1, 5'd2, 5'd9, 4'd2, 0);
        wait_done("post_flush", 7);
        chk("post_flush_w1", {27'd0, wlog_a[b_wr+1], wlog_s[b_wr+1], wlog_d[b_wr+1]}, {27'd0, 5'd9, 4'd1, 32'd2});

        // share-count clamping with rd=0 (no writes)
        send(4'd0, 5'd1, 5'd2, 5'd0, 4'd1, 0);
        wait_done("d1", 7);
        chk("d1_reads", 64'(nrd - b_rd), 64'd4);
        chk("d1_writes", 64'(nwr - b_wr), 64'd0);
        send(4'd0, 5'd4, 5'd5, 5'd0, 4'd9, 0);
        wait_done("d9", 13);
        chk("d9_reads", 64'(nrd - b_rd), 64'd8);
        chk("d9_writes", 64'(nwr - b_wr), 64'd0);

        // reset in the middle of the read phase
        send(4'd0, 5'd4, 5'd5, 5'd6, 4'd4, 0);
        chk("mid_rst_reading", 64'(bank_ren), 64'd1);
        g_reset = 1'b1;
        #1;
        chk("mid_rst_quiet", 64'({bank_ren, bank_wen, alu_valid, cmd_ready}), 64'd1);
        @(posedge g_clk); #1;
        g_reset = 1'b0;
        repeat (20) @(posedge g_clk);
        #1;
        chk("mid_rst_no_wr", 64'(nwr - b_wr), 64'd0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
